// File: rtl/dwc_hdmi_rx_ceavid_tgen_mp.sv
// rtl/dwc_hdmi_rx_ceavid_tgen_mp.sv - multi-pixel-per-clock CEA video timing regenerator
// Regenerates hsync/vsync/dataen per lane from shadowed timing and masks the aligned pixel bus.
module dwc_hdmi_rx_ceavid_tgen_mp #(
    parameter int PPC = 1,
    parameter int CW  = 16,
    parameter int TW  = 16
) (
    input  logic                  ihdmiclk,
    input  logic                  ihdmirst_n,
    input  logic                  ihdmien,
    input  logic                  icfg_ceavid_rst,
    input  logic                  istart,
    input  logic [TW-1:0]         ihfront,
    input  logic [TW-1:0]         ihsync_width,
    input  logic [TW-1:0]         ihblank,
    input  logic [TW-1:0]         ihactive,
    input  logic [TW-1:0]         ivfront,
    input  logic [TW-1:0]         ivsync_width,
    input  logic [TW-1:0]         ivblank,
    input  logic [TW-1:0]         ivactive,
    input  logic                  iilace,
    input  logic                  ihpol,
    input  logic                  ivpol,
    input  logic [3*CW*PPC-1:0]   idata,
    output logic [PPC-1:0]        ohsync,
    output logic [PPC-1:0]        ovsync,
    output logic [PPC-1:0]        odataen,
    output logic [3*CW*PPC-1:0]   odata,
    output logic                  ofield,
    output logic                  oframe_p,
    output logic                  ocfg_err
);

    localparam int PW = 3 * CW;
    localparam int SH = (PPC == 4) ? 2 : ((PPC == 2) ? 1 : 0);
    localparam logic [TW:0] ONE = {{TW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0][TW-1:0]     r_shd;
    logic [7:0][TW-1:0]     w_shd_in;
    logic [TW:0]            r_hcnt;
    logic [TW:0]            r_vcnt;
    logic                   r_field;
    logic                   r_cfg_err;
    logic [PPC-1:0]         r_ohsync;
    logic [PPC-1:0]         r_ovsync;
    logic [PPC-1:0]         r_odataen;
    logic [3*CW*PPC-1:0]    r_odata;
    logic                   r_ofield;
    logic                   r_oframe_p;

    logic                   w_clr;
    logic                   w_run;
    logic                   w_legal;
    logic [TW-1:0]          w_lsb_mask;
    logic [TW:0]            w_in_hsum;
    logic [TW:0]            w_in_vsum;
    logic [TW-1:0]          w_hfront;
    logic [TW-1:0]          w_hsw;
    logic [TW-1:0]          w_hblank;
    logic [TW-1:0]          w_hactive;
    logic [TW-1:0]          w_vfront;
    logic [TW-1:0]          w_vsw;
    logic [TW-1:0]          w_vblank;
    logic [TW-1:0]          w_vactive;
    logic [TW:0]            w_htot;
    logic [TW:0]            w_hclks;
    logic [TW:0]            w_hhalf;
    logic [TW:0]            w_hs_end;
    logic [TW:0]            w_vbl_eff;
    logic [TW:0]            w_vtot;
    logic [TW:0]            w_vs_end;
    logic [TW:0]            w_pbase;
    logic                   w_hlast;
    logic                   w_vlast;
    logic                   w_act_line;
    logic [PPC-1:0]         w_hs_act;
    logic [PPC-1:0]         w_vs_act;
    logic [PPC-1:0]         w_de;
    logic [3*CW*PPC-1:0]    w_data_m;

    assign w_clr = ~ihdmien | icfg_ceavid_rst;
    assign w_run = (r_state == ST_RUN);

    assign w_shd_in = {ivactive, ivblank, ivsync_width, ivfront,
                       ihactive, ihblank, ihsync_width, ihfront};

    // Legality is judged on the live inputs, which are the values latched in the same cycle.
    assign w_lsb_mask = TW'(PPC - 1);
    assign w_in_hsum  = {1'b0, ihfront} + {1'b0, ihsync_width};
    assign w_in_vsum  = {1'b0, ivfront} + {1'b0, ivsync_width};
    assign w_legal    = (((ihblank | ihactive | ihfront | ihsync_width) & w_lsb_mask) == '0)
                     && (w_in_hsum <= {1'b0, ihblank})
                     && (w_in_vsum <= {1'b0, ivblank})
                     && (ihactive != '0) && (ivactive != '0);

    assign w_hfront  = r_shd[0];
    assign w_hsw     = r_shd[1];
    assign w_hblank  = r_shd[2];
    assign w_hactive = r_shd[3];
    assign w_vfront  = r_shd[4];
    assign w_vsw     = r_shd[5];
    assign w_vblank  = r_shd[6];
    assign w_vactive = r_shd[7];

    assign w_htot     = {1'b0, w_hblank} + {1'b0, w_hactive};
    assign w_hclks    = w_htot >> SH;
    assign w_hhalf    = w_htot >> 1;
    assign w_hs_end   = {1'b0, w_hfront} + {1'b0, w_hsw};
    assign w_vbl_eff  = {1'b0, w_vblank} + {{TW{1'b0}}, r_field};
    assign w_vtot     = w_vbl_eff + {1'b0, w_vactive};
    assign w_vs_end   = {1'b0, w_vfront} + {1'b0, w_vsw};
    assign w_pbase    = r_hcnt << SH;
    assign w_hlast    = (r_hcnt == w_hclks - ONE);
    assign w_vlast    = (r_vcnt == w_vtot - ONE);
    assign w_act_line = (r_vcnt >= w_vbl_eff);

    for (genvar g = 0; g < PPC; g++) begin : g_lane
        logic [TW:0] w_p;
        assign w_p         = w_pbase + (TW+1)'(g);
        assign w_hs_act[g] = (w_p >= {1'b0, w_hfront}) && (w_p < w_hs_end);
        assign w_de[g]     = w_act_line && (w_p >= {1'b0, w_hblank});
        // Field 1 moves both vsync edges to mid-line of the boundary lines.
        assign w_vs_act[g] = r_field ?
            (((r_vcnt > {1'b0, w_vfront}) || ((r_vcnt == {1'b0, w_vfront}) && (w_p >= w_hhalf)))
             && ((r_vcnt < w_vs_end) || ((r_vcnt == w_vs_end) && (w_p < w_hhalf)))) :
            ((r_vcnt >= {1'b0, w_vfront}) && (r_vcnt < w_vs_end));
        assign w_data_m[g*PW +: PW] = (w_run && w_de[g]) ? idata[g*PW +: PW] : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (istart) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = w_legal ? ST_RUN : ST_IDLE;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ihdmiclk or negedge ihdmirst_n) begin
        if (!ihdmirst_n) begin
            r_state <= ST_IDLE;
        end else if (w_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ihdmiclk or negedge ihdmirst_n) begin
        if (!ihdmirst_n) begin
            r_shd     <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_field   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (w_clr) begin
            r_shd     <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_field   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_shd     <= w_shd_in;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_field   <= 1'b0;
            r_cfg_err <= ~w_legal;
        end else if (w_run) begin
            if (w_hlast) begin
                r_hcnt <= '0;
                if (w_vlast) begin
                    // Frame boundary: new timing is picked up here without re-checking.
                    r_vcnt  <= '0;
                    r_field <= iilace & ~r_field;
                    r_shd   <= w_shd_in;
                end else begin
                    r_vcnt <= r_vcnt + ONE;
                end
            end else begin
                r_hcnt <= r_hcnt + ONE;
            end
        end
    end

    always_ff @(posedge ihdmiclk or negedge ihdmirst_n) begin
        if (!ihdmirst_n) begin
            r_ohsync   <= '0;
            r_ovsync   <= '0;
            r_odataen  <= '0;
            r_odata    <= '0;
            r_ofield   <= 1'b0;
            r_oframe_p <= 1'b0;
        end else if (w_clr || !w_run) begin
            r_ohsync   <= '0;
            r_ovsync   <= '0;
            r_odataen  <= '0;
            r_odata    <= '0;
            r_ofield   <= 1'b0;
            r_oframe_p <= 1'b0;
        end else begin
            r_ohsync   <= w_hs_act ^ {PPC{~ihpol}};
            r_ovsync   <= w_vs_act ^ {PPC{~ivpol}};
            r_odataen  <= w_de;
            r_odata    <= w_data_m;
            r_ofield   <= r_field;
            r_oframe_p <= (r_hcnt == '0) && (r_vcnt == '0);
        end
    end

    assign ohsync   = r_ohsync;
    assign ovsync   = r_ovsync;
    assign odataen  = r_odataen;
    assign odata    = r_odata;
    assign ofield   = r_ofield;
    assign oframe_p = r_oframe_p;
    assign ocfg_err = r_cfg_err;

endmodule

// File: tb/tb_dwc_hdmi_rx_ceavid_tgen_mp.sv
// tb/tb_dwc_hdmi_rx_ceavid_tgen_mp.sv - scoreboard bench for the CEA timing regenerator
// Two instances (1 and 4 pixels per clock); per-cycle expected outputs are queued by the stimulus.
module tb_dwc_hdmi_rx_ceavid_tgen_mp;

    localparam int CW  = 16;
    localparam int TW  = 16;
    localparam int DW1 = 3 * CW;
    localparam int DW4 = 3 * CW * 4;
    localparam int BIG = 100000;

    typedef struct packed {
        logic [3:0] hs;
        logic [3:0] vs;
        logic [3:0] de;
        logic       fld;
        logic       fr;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en;
    logic [TW-1:0] hblank, vfront, vsw, vblank, vactive;
    logic ilace, hpol, vpol;

    logic start1, srst1;
    logic [TW-1:0] hf1, hsw1, ha1;
    logic [DW1-1:0] idata1, o_data1, prev1;
    logic [0:0] o_hs1, o_vs1, o_de1;
    logic o_fld1, o_fr1, o_err1;

    logic start4, srst4;
    logic [TW-1:0] hf4, hsw4, ha4;
    logic [DW4-1:0] idata4, o_data4, prev4;
    logic [3:0] o_hs4, o_vs4, o_de4;
    logic o_fld4, o_fr4, o_err4;

    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dwc_hdmi_rx_ceavid_tgen_mp #(.PPC(1), .CW(CW), .TW(TW)) u1 (
        .ihdmiclk(clk), .ihdmirst_n(rst_n), .ihdmien(en), .icfg_ceavid_rst(srst1),
        .istart(start1), .ihfront(hf1), .ihsync_width(hsw1), .ihblank(hblank),
        .ihactive(ha1), .ivfront(vfront), .ivsync_width(vsw), .ivblank(vblank),
        .ivactive(vactive), .iilace(ilace), .ihpol(hpol), .ivpol(vpol),
        .idata(idata1), .ohsync(o_hs1), .ovsync(o_vs1), .odataen(o_de1),
        .odata(o_data1), .ofield(o_fld1), .oframe_p(o_fr1), .ocfg_err(o_err1)
    );

    dwc_hdmi_rx_ceavid_tgen_mp #(.PPC(4), .CW(CW), .TW(TW)) u4 (
        .ihdmiclk(clk), .ihdmirst_n(rst_n), .ihdmien(en), .icfg_ceavid_rst(srst4),
        .istart(start4), .ihfront(hf4), .ihsync_width(hsw4), .ihblank(hblank),
        .ihactive(ha4), .ivfront(vfront), .ivsync_width(vsw), .ivblank(vblank),
        .ivactive(vactive), .iilace(ilace), .ihpol(hpol), .ivpol(vpol),
        .idata(idata4), .ohsync(o_hs4), .ovsync(o_vs4), .odataen(o_de4),
        .odata(o_data4), .ofield(o_fld4), .oframe_p(o_fr4), .ocfg_err(o_err4)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input exp_t e);
        if (sel == 1) q1.push_back(e);
        else q4.push_back(e);
    endtask

    task automatic push_idle(input int sel, input int n, input bit err);
        exp_t e;
        e = '0;
        e.err = err;
        for (int i = 0; i < n; i++) push(sel, e);
    endtask

    // Geometry arguments are hand-derived pixel/line boundaries for the programmed timing.
    task automatic push_frame(input int sel, input int ppc, input int nclk, input int nlines,
                              input int hs_a, input int hs_b, input int de_p, input int act_l,
                              input int vs_l0, input int vs_l1, input int vs_px,
                              input bit fld, input int limit);
        exp_t e;
        int p;
        int n;
        bit va;
        n = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int h = 0; h < nclk; h++) begin
                if (n < limit) begin
                    e = '0;
                    e.fld = fld;
                    e.fr = (l == 0) && (h == 0);
                    for (int k = 0; k < ppc; k++) begin
                        p = h * ppc + k;
                        e.hs[k] = ((p >= hs_a) && (p < hs_b)) ^ ~hpol;
                        va = ((l > vs_l0) || ((l == vs_l0) && (p >= vs_px)))
                          && ((l < vs_l1) || ((l == vs_l1) && (p < vs_px)));
                        e.vs[k] = va ^ ~vpol;
                        e.de[k] = (l >= act_l) && (p >= de_p);
                    end
                    push(sel, e);
                    n++;
                end
            end
        end
    endtask

    task automatic drain();
        while (q1.size() != 0 || q4.size() != 0) tick(1);
    endtask

    initial begin
        logic [63:0] w64;
        idata1 = '0;
        idata4 = '0;
        forever begin
            @(posedge clk);
            #1;
            w64 = {$urandom(), $urandom()};
            idata1 = w64[DW1-1:0];
            for (int i = 0; i < DW4 / 32; i++) idata4[32*i +: 32] = $urandom();
        end
    end

    initial begin
        exp_t m1, m4;
        logic [DW1-1:0] ed1;
        logic [DW4-1:0] ed4;
        prev1 = '0;
        prev4 = '0;
        forever begin
            @(negedge clk);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                ed1 = m1.de[0] ? prev1 : '0;
                checks++;
                if ({o_hs1, o_vs1, o_de1, o_fld1, o_fr1, o_err1} !==
                    {m1.hs[0], m1.vs[0], m1.de[0], m1.fld, m1.fr, m1.err} || o_data1 !== ed1) begin
                    failures++;
                    $display("FAIL ppc1_out t=%0t got hs,vs,de,fld,fr,err=%b data=%h want %b data=%h",
                             $time, {o_hs1, o_vs1, o_de1, o_fld1, o_fr1, o_err1}, o_data1,
                             {m1.hs[0], m1.vs[0], m1.de[0], m1.fld, m1.fr, m1.err}, ed1);
                end
            end
            if (q4.size() != 0) begin
                m4 = q4.pop_front();
                for (int k = 0; k < 4; k++) ed4[DW1*k +: DW1] = m4.de[k] ? prev4[DW1*k +: DW1] : '0;
                checks++;
                if ({o_hs4, o_vs4, o_de4, o_fld4, o_fr4, o_err4} !==
                    {m4.hs, m4.vs, m4.de, m4.fld, m4.fr, m4.err} || o_data4 !== ed4) begin
                    failures++;
                    $display("FAIL ppc4_out t=%0t got hs,vs,de,fld,fr,err=%b data=%h want %b data=%h",
                             $time, {o_hs4, o_vs4, o_de4, o_fld4, o_fr4, o_err4}, o_data4,
                             {m4.hs, m4.vs, m4.de, m4.fld, m4.fr, m4.err}, ed4);
                end
            end
            prev1 = idata1;
            prev4 = idata4;
        end
    end

    initial begin
        en = 1'b1; ilace = 1'b0; hpol = 1'b1; vpol = 1'b1;
        hblank = 16'd8; vfront = 16'd1; vsw = 16'd2; vblank = 16'd4; vactive = 16'd3;
        start1 = 1'b0; srst1 = 1'b0; hf1 = 16'd2; hsw1 = 16'd3; ha1 = 16'd16;
        start4 = 1'b0; srst4 = 1'b0; hf4 = 16'd0; hsw4 = 16'd4; ha4 = 16'd16;

        // Outputs held at zero while in reset.
        @(posedge clk);
        #1;
        push_idle(1, 4, 1'b0);
        push_idle(4, 4, 1'b0);
        tick(4);
        rst_n = 1'b1;
        drain();

        // Progressive 168-clock frame, ihactive change mid-frame, soft reset mid-active-line.
        start1 = 1'b1;
        push_idle(1, 3, 1'b0);
        push_frame(1, 1, 24, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, BIG);
        push_frame(1, 1, 28, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, BIG);
        push_frame(1, 1, 28, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, 123);
        push_idle(1, 20, 1'b0);
        tick(1);
        start1 = 1'b0;
        tick(49);
        ha1 = 16'd20;
        tick(439);
        srst1 = 1'b1;
        tick(1);
        srst1 = 1'b0;
        drain();
        ha1 = 16'd16;

        // Active-low polarity, then block disable mid-frame.
        hpol = 1'b0;
        vpol = 1'b0;
        start1 = 1'b1;
        push_idle(1, 3, 1'b0);
        push_frame(1, 1, 24, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, BIG);
        push_frame(1, 1, 24, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, 21);
        push_idle(1, 10, 1'b0);
        tick(1);
        start1 = 1'b0;
        tick(190);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        drain();
        hpol = 1'b1;
        vpol = 1'b1;

        // Interlace: 168/192-clock fields, field-1 vsync edges at pixel 12.
        ilace = 1'b1;
        start1 = 1'b1;
        push_idle(1, 3, 1'b0);
        push_frame(1, 1, 24, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, BIG);
        push_frame(1, 1, 24, 8, 2, 5, 8, 5, 1, 3, 12, 1'b1, BIG);
        push_frame(1, 1, 24, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, 5);
        push_idle(1, 10, 1'b0);
        tick(1);
        start1 = 1'b0;
        tick(366);
        srst1 = 1'b1;
        tick(1);
        srst1 = 1'b0;
        drain();
        ilace = 1'b0;

        // Illegal hfront+hsync > hblank, then a legal start clears the error.
        hf1 = 16'd6;
        start1 = 1'b1;
        push_idle(1, 2, 1'b0);
        push_idle(1, 8, 1'b1);
        tick(1);
        start1 = 1'b0;
        drain();
        hf1 = 16'd2;
        start1 = 1'b1;
        push_idle(1, 2, 1'b1);
        push_idle(1, 1, 1'b0);
        push_frame(1, 1, 24, 7, 2, 5, 8, 4, 1, 3, 0, 1'b0, 30);
        push_idle(1, 5, 1'b0);
        tick(1);
        start1 = 1'b0;
        tick(31);
        srst1 = 1'b1;
        tick(1);
        srst1 = 1'b0;
        drain();

        // Four pixels per clock, progressive, 6-clock lines with data checking.
        start4 = 1'b1;
        push_idle(4, 3, 1'b0);
        push_frame(4, 4, 6, 7, 0, 4, 8, 4, 1, 3, 0, 1'b0, BIG);
        push_frame(4, 4, 6, 7, 0, 4, 8, 4, 1, 3, 0, 1'b0, 10);
        push_idle(4, 5, 1'b0);
        tick(1);
        start4 = 1'b0;
        tick(53);
        srst4 = 1'b1;
        tick(1);
        srst4 = 1'b0;
        drain();

        // hactive not a multiple of 4 is rejected.
        ha4 = 16'd14;
        start4 = 1'b1;
        push_idle(4, 2, 1'b0);
        push_idle(4, 6, 1'b1);
        tick(1);
        start4 = 1'b0;
        drain();

        // Interlace at 4 PPC with htot 20: field-1 vsync edge lands mid-clock at pixel 10.
        ha4 = 16'd12;
        ilace = 1'b1;
        start4 = 1'b1;
        push_idle(4, 2, 1'b1);
        push_idle(4, 1, 1'b0);
        push_frame(4, 4, 5, 7, 0, 4, 8, 4, 1, 3, 0, 1'b0, BIG);
        push_frame(4, 4, 5, 8, 0, 4, 8, 5, 1, 3, 10, 1'b1, BIG);
        push_frame(4, 4, 5, 7, 0, 4, 8, 4, 1, 3, 0, 1'b0, 5);
        push_idle(4, 5, 1'b0);
        tick(1);
        start4 = 1'b0;
        tick(81);
        srst4 = 1'b1;
        tick(1);
        srst4 = 1'b0;
        drain();
        ilace = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwc_hdmi_rx_ceavid_tgen_mp.md
# dwc_hdmi_rx_ceavid_tgen_mp

Parametrised, multi-pixel-per-clock CEA video timing regenerator for the HDMI RX CEA video path. From programmed horizontal and vertical timing, it generates per-lane hsync, vsync and dataen for PPC pixels per clock, with interlace (field) support. It also aligns and masks an incoming pixel data bus to those timings. It sits between the alignment logic and the output FIFO, replacing the fixed single-pixel generator.

## Interface
Parameters:
- PPC, 1, pixels per clock; legal values are 1, 2 and 4.
- CW, 16, component width; each pixel is 3*CW bits.
- TW, 16, width of the timing fields.

Ports:
- ihdmiclk  in  1  Single clock for the block.
- ihdmirst_n  in  1  Reset, asynchronous, active-low.
- ihdmien  in  1  Block enable. When 0, the block behaves as if icfg_ceavid_rst were 1.
- icfg_ceavid_rst  in  1  Synchronous soft reset. Returns every register to its reset value.
- istart  in  1  Single-cycle pulse that arms and starts the generator.
- ihfront, ihsync_width, ihblank, ihactive  in  TW each  Horizontal timing, in pixels.
- ivfront, ivsync_width, ivblank, ivactive  in  TW each  Vertical timing, in lines.
- iilace, ihpol, ivpol  in  1 each  Interlace enable, hsync active level, vsync active level.
- idata  in  3*CW*PPC  Pixel data. Lane k occupies bits [3*CW*(k+1)-1 : 3*CW*k].
- ohsync, ovsync, odataen  out  PPC each  Per-lane sync and data-enable outputs, polarity applied.
- odata  out  3*CW*PPC  Aligned pixel data, masked by odataen.
- ofield  out  1  Current field: 0 = field 0 (or progressive), 1 = field 1.
- oframe_p  out  1  One-cycle pulse on the first pixel of every frame/field.
- ocfg_err  out  1  Sticky flag for an illegal configuration.

## Operation
- The FSM has three states: IDLE, CHECK and RUN. Reset and soft reset both return the FSM to IDLE.
- IDLE -> CHECK on istart. In CHECK, the timing inputs are latched into shadow registers.
- Legality check, performed in CHECK:
  - ihblank, ihactive, ihfront and ihsync_width must each be a multiple of PPC.
  - ihfront + ihsync_width <= ihblank.
  - ivfront + ivsync_width <= ivblank.
  - ihactive != 0 and ivactive != 0.
- CHECK -> RUN if the configuration is legal. Otherwise, ocfg_err is set and the FSM returns to IDLE.
- ocfg_err is cleared only by a reset or by the next legal istart.
- istart while in RUN is ignored.
- Horizontal counter hcnt counts clocks, 0 .. htot/PPC-1, where htot = hblank + hactive (computed at TW+1 bits).
- Lane k of a clock represents pixel p = hcnt*PPC + k.
- Vertical counter vcnt counts lines, 0 .. vtot-1.
  - Progressive, and interlace field 0: vtot = vblank + vactive.
  - Interlace field 1: vtot = vblank + 1 + vactive.
- Horizontal timing, per lane:
  - hsync active for hfront <= p < hfront + hsync_width.
  - dataen for p >= hblank, and only on active lines.
- Vertical blanking:
  - Active lines are vcnt >= vblank, or vcnt >= vblank+1 in field 1.
  - Progressive and field 0: vsync is active for whole lines, vfront <= vcnt < vfront + vsync_width, starting at p = 0.
  - Field 1: the vsync start and end are both shifted to pixel htot/2 (floor) of lines vfront and vfront + vsync_width.
- At the end of a frame, vcnt wraps to 0.
  - ofield toggles when iilace = 1 and is held at 0 otherwise.
  - The shadow timing registers reload from the inputs at every wrap, so configuration changes take effect only on a frame boundary.
  - A reload is not re-checked. Software must issue soft reset + istart to change multiplicity-related values.
- Polarity: output level = active XOR ~pol. With pol = 1 the signal is active-high.
- odata lane k = idata lane k from the previous clock when odataen[k] = 1; otherwise 0.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, ofield 0.
- The polarity inversion takes effect from the first RUN output cycle onward.
- istart in cycle T:
  - CHECK occupies T+1.
  - The first RUN counter state (vcnt = 0, hcnt = 0, field 0) occurs in T+2.
  - The registered outputs for that state, including oframe_p = 1, appear in T+3.
- Output latency is one clock from counter state to ohsync/ovsync/odataen/odata.
- oframe_p is asserted in the output cycle for vcnt = 0, hcnt = 0 of every field.
- An asynchronous reset mid-frame takes effect immediately.
- A soft reset or ihdmien = 0 mid-frame takes effect on the next clock. All outputs are 0 on the following cycle.

## Test plan
- PPC=1, hfront=2, hsync=3, hblank=8, hactive=16, vfront=1, vsync=2, vblank=4, vactive=3, progressive, pol=1:
  - oframe_p every 168 clocks.
  - Each line: ohsync high for clocks 2-4, odataen high for clocks 8-23.
  - ovsync high for lines 1-2 (48 clocks).
  - 48 data-enable clocks per frame.
- Same timing with PPC=4 (hblank=8, hactive=16, hfront=0, hsync=4):
  - htot = 6 clocks; odataen = 4'b1111 for clocks 2-5 of each active line.
  - odata is the prior-cycle idata.
- Interlace, PPC=1, same timing:
  - Frames alternate between 168 and 192 clocks.
  - ofield toggles at each wrap.
  - In field 1, ovsync rises at pixel 12 of line 1 and falls at pixel 12 of line 3.
- Illegal configuration, PPC=2 with hactive=15 + istart:
  - ocfg_err = 1 at T+2, FSM stays in IDLE, outputs stay 0.
  - A later legal istart clears ocfg_err.
- pol=0: ohsync/ovsync idle high and pulse low.
- Assert icfg_ceavid_rst mid-active-line: all outputs are 0 on the next cycle, and no output occurs until a new istart.
- Change ihactive mid-frame: the current frame keeps the old line length, and the new length applies from the next oframe_p.
